// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: round-robin grant, one-cycle execute, then a held
// response until the consumer accepts it.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req0_op,
    input  logic [1:0]        req1_op,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_carry,
    output logic              resp_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [1:0]        op_reg, op_next;
    logic              id_reg, id_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              carry_reg, carry_next;

    logic [1:0]        valid_vec;
    logic [1:0]        grant_vec;
    logic              winner;
    logic              take;
    logic [DATA_W:0]   alu_res;

    assign valid_vec = {req1_valid, req0_valid};
    // Pointer only matters under contention; a lone requester always wins.
    assign winner    = (&valid_vec) ? ptr_reg : valid_vec[1];
    assign take      = (state_reg == IDLE) && reset_n && (|valid_vec);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_vec[gi] = take && (winner == 1'(gi));
        end
    endgenerate

    assign req0_ready = grant_vec[0];
    assign req1_ready = grant_vec[1];

    always_comb begin
        alu_res = '0;
        case (op_reg)
            2'b00:   alu_res = {1'b0, a_reg} + {1'b0, b_reg};
            2'b01:   alu_res = {1'b0, a_reg & b_reg};
            2'b10:   alu_res = {2'b00, a_reg[DATA_W-1:1]};
            default: alu_res = {1'b0, a_reg} + (DATA_W+1)'(1);
        endcase
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        id_next    = id_reg;
        data_next  = data_reg;
        carry_next = carry_reg;
        case (state_reg)
            IDLE: begin
                if (take) begin
                    a_next     = winner ? req1_a  : req0_a;
                    b_next     = winner ? req1_b  : req0_b;
                    op_next    = winner ? req1_op : req0_op;
                    id_next    = winner;
                    ptr_next   = ~winner;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                data_next  = alu_res[DATA_W-1:0];
                carry_next = alu_res[DATA_W];
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            id_reg    <= 1'b0;
            data_reg  <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_next;
            id_reg    <= id_next;
            data_reg  <= data_next;
            carry_reg <= carry_next;
        end
    end

    assign resp_valid = (state_reg == RESP);
    assign busy       = (state_reg != IDLE);
    assign resp_data  = data_reg;
    assign resp_carry = carry_reg;
    assign resp_id    = id_reg;

endmodule
